instr_fetch: RTL and testbench

- Fetch stage directly downstream of program_counter in the Single-Cycle core.
- Takes Program_Count, issues one word read per instruction on a valid/ready instruction-memory bus, and holds the returned instruction for decode.
- Drives Fetch_Stall back to the PC so the PC register only advances once the current instruction has been consumed.
- Handles redirect flushes (branch/jump) and misaligned PCs.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stall_counter.sv | 32 +++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN (stall-cycle counter).
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP  = 32'h0000_0013;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_stall_counter.sv
// Free-running 32-bit wrapping counter of fetch stall cycles.
// Instantiated by instr_fetch only when FETCH_PERF_CNT_EN is defined.
module fetch_stall_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Advance by one on each enabled cycle; natural wrap at all-ones.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one imem read per instruction, holds result for decode.
// Optional: FETCH_PERF_CNT_EN adds the Stall_Cycles output.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(FETCH_NOP)
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic [ADDR_W-1:0] Program_Count,
    input  logic              Flush,
    output logic              Fetch_Stall,
    output logic              Imem_Req_Valid,
    input  logic              Imem_Req_Ready,
    output logic [ADDR_W-1:0] Imem_Req_Addr,
    input  logic              Imem_Rsp_Valid,
    input  logic [DATA_W-1:0] Imem_Rsp_Data,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_PC,
    output logic              Instr_Fault
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       Stall_Cycles
`endif
);

    fetch_state_e      state_q, state_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              valid_q, valid_d;
    logic              stall;
    logic              misaligned;

    assign misaligned = |(Program_Count[1:0] & ALIGN_MASK);

    // Next-state, datapath updates and PC stall decision.
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        valid_d    = valid_q;
        stall      = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (misaligned) begin
                    instr_d = NOP_INSTR;
                    pc_d    = Program_Count;
                    fault_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    req_addr_d = Program_Count;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Request stays up; a redirect only marks its data stale.
                if (Flush) begin
                    discard_d = 1'b1;
                    stall     = 1'b0;
                end
                if (Imem_Req_Ready) begin
                    pc_d    = req_addr_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (Flush) begin
                    stall = 1'b0;
                end
                if (Imem_Rsp_Valid) begin
                    if (discard_q || Flush) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_d = Imem_Rsp_Data;
                        fault_d = 1'b0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (Flush) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (Instr_Ready || Flush) begin
                    valid_d = 1'b0;
                    stall   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q    <= IDLE;
            discard_q  <= 1'b0;
            req_addr_q <= '0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            fault_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            valid_q    <= valid_d;
        end
    end

    assign Fetch_Stall    = stall;
    assign Imem_Req_Valid = (state_q == REQ);
    assign Imem_Req_Addr  = req_addr_q;
    assign Instr_Valid    = valid_q;
    assign Instr          = instr_q;
    assign Instr_PC       = pc_q;
    assign Instr_Fault    = fault_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_stall_counter u_stall_cnt (
        .clk_i   (Clk_Core),
        .rst_ni  (Rst_Core_N),
        .en_i    (stall),
        .count_o (Stall_Cycles)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch, flush, fault,
// back-pressure and async reset scenarios.
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        Clk_Core;
    logic        Rst_Core_N;
    logic [31:0] Program_Count;
    logic        Flush;
    logic        Fetch_Stall;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Stall_Cycles;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr_q[$];
    exp_t        exp_ins_q[$];
    int          rsp_delay = 0;
    logic [31:0] rsp_data  = 32'h0;
    int          rsp_cnt   = -1;

    instr_fetch dut (
        .Clk_Core       (Clk_Core),
        .Rst_Core_N     (Rst_Core_N),
        .Program_Count  (Program_Count),
        .Flush          (Flush),
        .Fetch_Stall    (Fetch_Stall),
        .Imem_Req_Valid (Imem_Req_Valid),
        .Imem_Req_Ready (Imem_Req_Ready),
        .Imem_Req_Addr  (Imem_Req_Addr),
        .Imem_Rsp_Valid (Imem_Rsp_Valid),
        .Imem_Rsp_Data  (Imem_Rsp_Data),
        .Instr_Valid    (Instr_Valid),
        .Instr_Ready    (Instr_Ready),
        .Instr          (Instr),
        .Instr_PC       (Instr_PC),
        .Instr_Fault    (Instr_Fault)
`ifdef FETCH_PERF_CNT_EN
       ,.Stall_Cycles   (Stall_Cycles)
`endif
    );

    initial Clk_Core = 1'b0;
    always #5 Clk_Core = ~Clk_Core;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers rsp_delay cycles after each acceptance.
    always begin
        @(negedge Clk_Core);
        if (Imem_Req_Valid && Imem_Req_Ready) rsp_cnt = rsp_delay;
        @(posedge Clk_Core);
        #1;
        if (rsp_cnt == 0) begin
            Imem_Rsp_Valid = 1'b1;
            Imem_Rsp_Data  = rsp_data;
        end else begin
            Imem_Rsp_Valid = 1'b0;
        end
        if (rsp_cnt >= 0) rsp_cnt--;
    end

    // Monitor: checks accepted requests and consumed instructions.
    always @(negedge Clk_Core) begin
        if (Rst_Core_N) begin
            if (Imem_Req_Valid && Imem_Req_Ready) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_req", Imem_Req_Addr, 32'hxxxxxxxx);
                end else begin
                    chk("req_addr", Imem_Req_Addr, exp_addr_q.pop_front());
                end
            end
            if (Instr_Valid && (Instr_Ready || Flush)) begin
                if (exp_ins_q.size() == 0) begin
                    chk("unexpected_instr", Instr, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = exp_ins_q.pop_front();
                    chk("instr", Instr, e.instr);
                    chk("instr_pc", Instr_PC, e.pc);
                    chk("instr_fault", {31'd0, Instr_Fault}, {31'd0, e.fault});
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, {31'd0, Imem_Req_Valid}, 32'd0);
        chk({tag, "_req_addr"}, Imem_Req_Addr, 32'd0);
        chk({tag, "_instr_valid"}, {31'd0, Instr_Valid}, 32'd0);
        chk({tag, "_instr"}, Instr, 32'h00000013);
        chk({tag, "_instr_pc"}, Instr_PC, 32'd0);
        chk({tag, "_fault"}, {31'd0, Instr_Fault}, 32'd0);
        chk({tag, "_stall"}, {31'd0, Fetch_Stall}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_stall_cycles"}, Stall_Cycles, 32'd0);
`endif
    endtask

    initial begin
        int nstall;
        int seen;
        Rst_Core_N     = 1'b0;
        Program_Count  = 32'h0;
        Flush          = 1'b0;
        Imem_Req_Ready = 1'b1;
        Imem_Rsp_Valid = 1'b0;
        Imem_Rsp_Data  = 32'h0;
        Instr_Ready    = 1'b1;
        rsp_delay      = 0;
        rsp_data       = 32'h00500093;

        // Scenario 1: basic zero-wait fetch loop.
        exp_addr_q.push_back(32'h0);
        exp_ins_q.push_back('{32'h00500093, 32'h0, 1'b0});
        repeat (2) @(negedge Clk_Core);
        chk_reset_vals("rst");
        Rst_Core_N = 1'b1;
        nstall = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) Imem_Req_Ready = 1'b0;
            @(negedge Clk_Core);
            if (!Fetch_Stall) nstall++;
        end
        chk("s1_stall_low_cycles", nstall, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("s1_stall_cycles", Stall_Cycles, 32'd5);
`endif

        // Scenario 2: request back-pressure keeps address stable.
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) Program_Count = 32'h40;
            @(negedge Clk_Core);
            chk("s2_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
            chk("s2_req_addr", Imem_Req_Addr, 32'h0);
            chk("s2_stall", {31'd0, Fetch_Stall}, 32'd1);
        end
        exp_addr_q.push_back(32'h0);
        exp_ins_q.push_back('{32'h00A00113, 32'h0, 1'b0});
        tick();
        Imem_Req_Ready = 1'b1;
        Instr_Ready    = 1'b0;
        rsp_data       = 32'h00A00113;
        tick();
        Imem_Req_Ready = 1'b0;
        tick();

        // Scenario 5: decode back-pressure, then flush+ready together.
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk_Core);
            chk("s5_instr_stable", Instr, 32'h00A00113);
            chk("s5_stall", {31'd0, Fetch_Stall}, 32'd1);
            chk("s5_valid", {31'd0, Instr_Valid}, 32'd1);
            tick();
        end
        Flush       = 1'b1;
        Instr_Ready = 1'b1;
        @(negedge Clk_Core);
        chk("s5_release_stall", {31'd0, Fetch_Stall}, 32'd0);
        tick();
        Flush       = 1'b0;
        Instr_Ready = 1'b0;
        @(negedge Clk_Core);
        chk("s5_idle_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("s5_idle_stall", {31'd0, Fetch_Stall}, 32'd1);

        // Scenario 3: flush while waiting drops the stale response.
        exp_addr_q.push_back(32'h40);
        rsp_delay = 1;
        rsp_data  = 32'hDEADBEEF;
        tick();
        Imem_Req_Ready = 1'b1;
        tick();
        Imem_Req_Ready = 1'b0;
        Flush          = 1'b1;
        Program_Count  = 32'h100;
        @(negedge Clk_Core);
        chk("s3_flush_stall", {31'd0, Fetch_Stall}, 32'd0);
        tick();
        Flush = 1'b0;
        exp_addr_q.push_back(32'h100);
        exp_ins_q.push_back('{32'h00C00193, 32'h100, 1'b0});
        Imem_Req_Ready = 1'b1;
        Instr_Ready    = 1'b1;
        rsp_delay      = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk_Core);
            if (Instr_Valid) seen++;
            if (i == 0) rsp_data = 32'h00C00193;
        end
        chk("s3_no_valid", seen, 32'd0);
        tick();
        Imem_Req_Ready = 1'b0;
        Program_Count  = 32'h102;

        // Scenario 4: misaligned PC yields a NOP fault, no request.
        tick();
        Instr_Ready = 1'b0;
        exp_ins_q.push_back('{32'h00000013, 32'h102, 1'b1});
        @(negedge Clk_Core);
        chk("s4_idle_no_req", {31'd0, Imem_Req_Valid}, 32'd0);
        tick();
        @(negedge Clk_Core);
        chk("s4_no_req", {31'd0, Imem_Req_Valid}, 32'd0);
        chk("s4_fault", {31'd0, Instr_Fault}, 32'd1);
        chk("s4_instr", Instr, 32'h00000013);
        chk("s4_pc", Instr_PC, 32'h102);
        chk("s4_valid", {31'd0, Instr_Valid}, 32'd1);
        tick();
        Instr_Ready   = 1'b1;
        Program_Count = 32'h200;
        tick();
        Instr_Ready = 1'b0;
        exp_addr_q.push_back(32'h200);
        Imem_Req_Ready = 1'b1;
        rsp_data       = 32'h00100073;

        // Scenario 6: async reset between edges while waiting.
        tick();
        tick();
        Imem_Req_Ready = 1'b0;
        chk("s6_pre_addr", Imem_Req_Addr, 32'h200);
        #3;
        Rst_Core_N = 1'b0;
        #1;
        chk_reset_vals("s6");

        chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
        chk("instr_queue_empty", exp_ins_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
